uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter: the serializing counterpart of the UART receive path. Accepts one parallel byte with a single-cycle valid strobe and shifts out a standard asynchronous frame on `TX_OUT`: start bit, data LSB first, optional even/odd parity, stop bit. `CLK` runs at the baud rate, so one bit is sent per `CLK` cycle. It sits in the UART top next to the RX path; parallel data comes from the system controller or a FIFO.

## Interface
- `DATA_WIDTH`, 8, width of the parallel data word and number of data bits per frame.
- `CLK` input 1: TX clock, one bit period per cycle.
- `RST` input 1: asynchronous, active-low reset.
- `P_DATA` input DATA_WIDTH: byte to transmit; sampled only on acceptance.
- `Data_Valid` input 1: request strobe; accepted when high on a rising edge with `Busy`=0.
- `PAR_EN` input 1: 1 = insert a parity bit; sampled on acceptance.
- `PAR_TYP` input 1: 0 = even, 1 = odd; sampled on acceptance.
- `TX_OUT` output 1: serial line, idle high; registered.
- `Busy` output 1: high from the start bit through the stop bit; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `TX_OUT`=1, `Busy`=0. On a rising edge with `Data_Valid`=1:
  - latch `P_DATA`, `PAR_EN`, `PAR_TYP` into internal registers;
  - go to START.
- START: `TX_OUT`=0 for one cycle, then DATA.
- DATA: `TX_OUT`=latched bit[i], i = 0..DATA_WIDTH-1, one bit per cycle, LSB first.
  - Bit counter width is clog2(DATA_WIDTH); it clears on entry.
  - After bit DATA_WIDTH-1: go to PARITY if latched `PAR_EN`=1, else STOP.
- PARITY: `TX_OUT` = XOR-reduce(latched data) when even; its inverse when odd. One cycle, then STOP.
- STOP: `TX_OUT`=1 for one cycle, then IDLE, with `Busy` falling on that edge.
- `Data_Valid` is ignored while `Busy`=1. Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` during a frame have no effect on it.
- Parity is computed from the latched data only, never from live `P_DATA`.
- Reset (any time, including mid-frame) forces:
  - state IDLE, `TX_OUT`=1, `Busy`=0;
  - data, config and counter registers cleared.
  - The line returns high immediately; the truncated frame is not resumed.

## Timing
- Reset values: `TX_OUT`=1, `Busy`=0.
- Acceptance edge E (IDLE, `Data_Valid`=1). After E: `TX_OUT`=0 and `Busy`=1. This is the start-bit cycle, so latency to the start bit is 1 cycle.
- Data bit i is driven during the cycle after edge E+1+i.
- Frame length with `Busy`=1: DATA_WIDTH+2 cycles (10) without parity, DATA_WIDTH+3 cycles (11) with parity.
- `Busy` falls on the edge that ends the stop bit. The earliest next acceptance is that same following edge, giving one idle-high cycle minimum between frames. Max throughput is one frame per 11 cycles (no parity) or 12 cycles (parity).
- `TX_OUT` is glitch-free: it is driven directly from a flop, with no combinational output path.
- `Data_Valid` held high continuously means a new frame is accepted at every IDLE cycle, producing back-to-back frames separated by one idle cycle.

## Test plan
- 0xA5, `PAR_EN`=0, one-cycle strobe:
  - `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1;
  - `Busy` high exactly 10 cycles; line idle high before and after.
- 0xA5 with even parity, then odd parity:
  - parity bit 0 (even) and 1 (odd) in cycle 10;
  - stop bit in cycle 11; `Busy` high 11 cycles.
- 0x07, even parity:
  - data 1,1,1,0,0,0,0,0, parity 1, stop 1;
  - `P_DATA` changed to 0xFF and `PAR_TYP` toggled at data bit 3, with no effect on the frame.
- `Data_Valid` pulsed during data bits of a frame carrying 0x3C: pulse ignored, exactly one frame of 0x3C is sent, and `Busy` then falls.
- `Data_Valid` held high with `P_DATA`=0x55 then 0xAA, `PAR_EN`=0:
  - two frames, one idle-high cycle between them;
  - second frame carries the value present at its acceptance edge.
- `RST` asserted during data bit 4 of 0x00:
  - `TX_OUT`=1 and `Busy`=0 asynchronously;
  - after release, no output until a new strobe; next frame of 0x81 is correct.

Source files
------------

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - parallel request and serial line bundle for the UART transmitter
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  // The system side issuing bytes.
  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  // The transmitter.
  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - baud-rate clocked UART frame serializer with optional parity
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  // A single-bit counter still needs one flop when DATA_WIDTH is 1.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_tx_out;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_last_bit;
  logic                  w_parity_bit;
  logic [CNT_W-1:0]      w_bit_sel;
  logic                  w_tx_next;
  logic                  w_busy_next;

  // A request is only taken while the line is idle; strobes during a frame are dropped.
  assign w_accept     = (r_state == S_IDLE) && bus.Data_Valid;
  assign w_last_bit   = (r_cnt == LAST_BIT);
  // Even parity is the XOR of the latched byte; odd parity inverts it.
  assign w_parity_bit = (^r_data) ^ r_par_typ;
  // Outputs are registered, so the bit chosen now is the one shown next cycle:
  // from START that is bit 0, from DATA it is the bit after the current one.
  assign w_bit_sel    = (r_state == S_DATA) ? (r_cnt + CNT_W'(1)) : '0;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and the line/busy values to register for the next cycle.
  always_comb begin
    w_next_state = r_state;
    w_tx_next    = 1'b1;
    w_busy_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.Data_Valid) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_next_state = S_DATA;
      end
      S_DATA: begin
        if (w_last_bit) begin
          w_next_state = r_par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        w_next_state = S_STOP;
      end
      S_STOP: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    case (w_next_state)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = r_data[w_bit_sel];
      S_PARITY: w_tx_next = w_parity_bit;
      default:  w_tx_next = 1'b1;
    endcase

    w_busy_next = (w_next_state != S_IDLE);
  end

  // Byte and framing options are captured once at acceptance and held for the whole frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_accept) begin
      r_data    <= bus.P_DATA;
      r_par_en  <= bus.PAR_EN;
      r_par_typ <= bus.PAR_TYP;
    end
  end

  // Bit counter: cleared while entering DATA, then advanced once per data bit.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (r_state == S_START) begin
      r_cnt <= '0;
    end else if (r_state == S_DATA) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Line and busy flops; the serial output never passes through combinational logic.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx_out <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_tx_out <= w_tx_next;
      r_busy   <= w_busy_next;
    end
  end

  assign bus.TX_OUT = r_tx_out;
  assign bus.Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a frame-level reference model
module tb_uart_tx;

  localparam int DW = 8;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  frame_t exp_q[$];
  int     m_rem;
  int     n_acc;

  // Frame as it should appear on the line: start, data LSB first, optional parity, stop.
  function automatic frame_t make_frame(logic [DW-1:0] d, logic pen, logic ptyp);
    frame_t f;
    int ones;
    int n;
    ones   = 0;
    f.bits = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) begin
      f.bits[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = DW + 1;
    if (pen) begin
      f.bits[n] = ((ones % 2) == 1) ? ~ptyp : ptyp;
      n++;
    end
    f.bits[n] = 1'b1;
    f.len = n + 1;
    return f;
  endfunction

  // Reference model: tracks how many busy cycles remain and queues the frame at each acceptance.
  initial begin
    m_rem = 0;
    n_acc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_rem = 0;
      end else if (m_rem == 0) begin
        if (bus.Data_Valid) begin
          exp_q.push_back(make_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP));
          m_rem = bus.PAR_EN ? DW + 3 : DW + 2;
          n_acc++;
        end
      end else begin
        m_rem--;
      end
    end
  end

  // Monitor: collects line bits while Busy is high and scores each completed or aborted frame.
  initial begin
    logic [15:0] cur_bits;
    int          cur_len;
    logic        prev_busy;
    frame_t      e;
    cur_bits  = '0;
    cur_len   = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (cur_len > 0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL abort_frame: truncated frame with no queued expectation, bits=%h", cur_bits);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < cur_len; i++) begin
              if (cur_bits[i] !== e.bits[i]) begin
                errors++;
                $display("FAIL abort_prefix: bit %0d got %b want %b", i, cur_bits[i], e.bits[i]);
                break;
              end
            end
          end
        end
        cur_len   = 0;
        cur_bits  = '0;
        prev_busy = 1'b0;
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
          errors++;
          $display("FAIL reset_state: TX_OUT=%b Busy=%b want TX_OUT=1 Busy=0", bus.TX_OUT, bus.Busy);
        end
      end else begin
        checks++;
        if (bus.Busy !== (m_rem != 0)) begin
          errors++;
          $display("FAIL busy_track: Busy=%b want %b", bus.Busy, (m_rem != 0));
        end
        if (bus.Busy === 1'b1) begin
          if (cur_len < 16) cur_bits[cur_len] = bus.TX_OUT;
          cur_len++;
        end else begin
          checks++;
          if (bus.TX_OUT !== 1'b1) begin
            errors++;
            $display("FAIL idle_line: TX_OUT=%b want 1", bus.TX_OUT);
          end
          if (prev_busy) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL frame_unexpected: got bits=%h len=%0d with nothing queued", cur_bits, cur_len);
            end else begin
              e = exp_q.pop_front();
              if (cur_len != e.len || cur_bits !== e.bits) begin
                errors++;
                $display("FAIL frame: got bits=%h len=%0d want bits=%h len=%0d", cur_bits, cur_len, e.bits, e.len);
              end
            end
          end
          cur_len  = 0;
          cur_bits = '0;
        end
        prev_busy = bus.Busy;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_rem != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (m_rem != 0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: model still busy, remaining=%0d want 0", m_rem);
    end
  endtask

  // Present one request for a single cycle, timed to an idle slot of the model.
  task automatic send(logic [DW-1:0] d, logic pen, logic ptyp);
    wait_idle();
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = ptyp;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
  endtask

  initial begin
    int base;
    int t;
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 0xA5 without parity, then with even and odd parity.
    send(8'hA5, 1'b0, 1'b0);
    send(8'hA5, 1'b1, 1'b0);
    send(8'hA5, 1'b1, 1'b1);

    // 0x07 even parity; inputs disturbed during data bit 3.
    send(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    bus.P_DATA  = 8'hFF;
    bus.PAR_TYP = 1'b1;

    // 0x3C with a stray strobe during its data bits.
    send(8'h3C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.P_DATA     = 8'hE1;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;

    // Data_Valid held high: 0x55 then 0xAA back to back.
    wait_idle();
    base           = n_acc;
    bus.P_DATA     = 8'h55;
    bus.PAR_EN     = 1'b0;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.P_DATA = 8'hAA;
    t = 0;
    while (n_acc < base + 2 && t < 40) begin
      @(negedge clk);
      t++;
    end
    bus.Data_Valid = 1'b0;
    checks++;
    if (n_acc != base + 2) begin
      errors++;
      $display("FAIL held_valid: accepted %0d frames want 2", n_acc - base);
    end

    // Reset during data bit 4 of 0x00, then a clean 0x81 frame.
    send(8'h00, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: TX_OUT=%b Busy=%b want TX_OUT=1 Busy=0", bus.TX_OUT, bus.Busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h81, 1'b1, 1'b1);

    // Randomised frames with occasional stray strobes and mid-frame input changes.
    for (int n = 0; n < 40; n++) begin
      send(DW'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 9) < 3) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        bus.P_DATA     = DW'($urandom);
        bus.PAR_EN     = 1'($urandom);
        bus.PAR_TYP    = 1'($urandom);
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames never seen, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
